// File: rtl/plic_target_arb.sv
// plic_target_arb: per-hart PLIC gateways, priority arbitration, threshold compare and claim/complete sequencing
module plic_target_arb #(
  parameter int NSRC = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NSRC-1:0]   src_i,
  input  logic [NSRC-1:0]   ie_i,
  input  logic [3*NSRC-1:0] prio_i,
  input  logic [2:0]        thresh_i,
  input  logic              claim_i,
  input  logic              complete_i,
  input  logic [3:0]        complete_id_i,
  output logic              irq_o,
  output logic [3:0]        claim_id_o,
  output logic              claim_vld_o,
  output logic [NSRC-1:0]   pending_o
);
  logic [NSRC-1:0] pend_q, pend_d, busy_q, busy_d;
  logic [3:0]      best_id_q, best_id_d;
  logic [2:0]      best_prio_q, best_prio_d;
  // strict compare in ascending ID order makes ties go to the lowest ID and excludes prio 0
  always_comb begin
    best_id_d = '0;
    best_prio_d = '0;
    for (int i = 0; i < NSRC; i++)
      if (pend_q[i] && ie_i[i] && prio_i[3*i +: 3] > best_prio_d) begin
        best_id_d = 4'(i + 1);
        best_prio_d = prio_i[3*i +: 3];
      end
  end
  always_comb begin
    pend_d = pend_q;
    busy_d = busy_q;
    for (int i = 0; i < NSRC; i++)
      if (busy_q[i]) busy_d[i] = !(complete_i && complete_id_i == 4'(i + 1));
      else if (pend_q[i]) begin
        busy_d[i] = claim_i && best_id_q == 4'(i + 1);
        pend_d[i] = !busy_d[i];
      end else pend_d[i] = src_i[i];
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      pend_q <= '0;
      busy_q <= '0;
      best_id_q <= '0;
      best_prio_q <= '0;
      irq_o <= 1'b0;
      claim_id_o <= '0;
      claim_vld_o <= 1'b0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      best_id_q <= best_id_d;
      best_prio_q <= best_prio_d;
      irq_o <= best_prio_q > thresh_i;
      claim_vld_o <= claim_i;
      claim_id_o <= claim_i ? best_id_q : claim_id_o;
    end
  assign pending_o = pend_q;
endmodule

// File: tb/tb_plic_target_arb.sv
// tb_plic_target_arb: directed test-plan scenarios plus random traffic against a gateway-array reference model
module tb_plic_target_arb;
  localparam int NSRC = 15;
  logic              clk = 0, rst = 0;
  logic [NSRC-1:0]   src = '0, ie = '0;
  logic [3*NSRC-1:0] prio = '0;
  logic [2:0]        thresh = '0;
  logic              claim = 0, complete = 0;
  logic [3:0]        complete_id = '0;
  logic              irq, claim_vld;
  logic [3:0]        claim_id;
  logic [NSRC-1:0]   pending;
  int vectors = 0, errors = 0;
  int gw[16];
  int m_bid, m_bprio, m_irq, m_cid, m_cvld;

  plic_target_arb #(.NSRC(NSRC)) dut (
    .clk_i(clk), .rst_i(rst), .src_i(src), .ie_i(ie), .prio_i(prio), .thresh_i(thresh),
    .claim_i(claim), .complete_i(complete), .complete_id_i(complete_id),
    .irq_o(irq), .claim_id_o(claim_id), .claim_vld_o(claim_vld), .pending_o(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pr(input int k);
    logic [3*NSRC-1:0] p;
    p = prio;
    return int'(p[3*k-1 -: 3]);
  endfunction

  task automatic cfg(input int k, input int p, input bit en);
    prio[3*k-1 -: 3] = 3'(p);
    ie[k-1] = en;
  endtask

  // gw: 0 idle, 1 pending, 2 in service
  task automatic tick();
    int ngw[16];
    int bid, bp, pm;
    bid = 0;
    bp = 0;
    for (int k = 1; k <= NSRC; k++)
      if (gw[k] == 1 && ie[k-1] && pr(k) > bp) begin
        bid = k;
        bp = pr(k);
      end
    for (int k = 1; k <= NSRC; k++) ngw[k] = (gw[k] == 0 && src[k-1]) ? 1 : gw[k];
    if (claim && m_bid != 0 && gw[m_bid] == 1) ngw[m_bid] = 2;
    if (complete && complete_id >= 1 && complete_id <= NSRC && gw[complete_id] == 2) ngw[complete_id] = 0;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 1; k <= NSRC; k++) gw[k] = 0;
      {m_bid, m_bprio, m_irq, m_cid, m_cvld} = '0;
    end else begin
      m_irq = int'(m_bprio > int'(thresh));
      m_cvld = int'(claim);
      if (claim) m_cid = m_bid;
      m_bid = bid;
      m_bprio = bp;
      for (int k = 1; k <= NSRC; k++) gw[k] = ngw[k];
    end
    pm = 0;
    for (int k = 1; k <= NSRC; k++) if (gw[k] == 1) pm |= 1 << (k - 1);
    chk("irq", int'(irq), m_irq);
    chk("claim_id", int'(claim_id), m_cid);
    chk("claim_vld", int'(claim_vld), m_cvld);
    chk("pending", int'(pending), pm);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_claim();
    claim = 1;
    tick();
    claim = 0;
  endtask

  task automatic do_complete(input int id);
    complete = 1;
    complete_id = 4'(id);
    tick();
    complete = 0;
  endtask

  initial begin
    int exp_ids[4];
    exp_ids = '{5, 7, 2, 0};
    for (int k = 0; k < 16; k++) gw[k] = 0;
    {m_bid, m_bprio, m_irq, m_cid, m_cvld} = '0;
    rst = 1;
    ticks(2);
    rst = 0;
    chk("rst_irq", int'(irq), 0);
    chk("rst_pend", int'(pending), 0);
    // single source
    cfg(3, 5, 1);
    src[2] = 1;
    tick();
    src[2] = 0;
    chk("single_pend", int'(pending[2]), 1);
    tick();
    chk("single_irq_early", int'(irq), 0);
    tick();
    chk("single_irq", int'(irq), 1);
    do_claim();
    chk("single_claim_id", int'(claim_id), 3);
    chk("single_claim_vld", int'(claim_vld), 1);
    tick();
    chk("single_vld_pulse", int'(claim_vld), 0);
    chk("single_irq_hold", int'(irq), 1);
    tick();
    chk("single_irq_off", int'(irq), 0);
    do_complete(3);
    ticks(2);
    // priority and tie order
    cfg(2, 4, 1);
    cfg(5, 6, 1);
    cfg(7, 6, 1);
    src = 15'b000_0000_0101_0010;
    tick();
    src = '0;
    ticks(2);
    for (int i = 0; i < 4; i++) begin
      do_claim();
      chk("prio_claim", int'(claim_id), exp_ids[i]);
      ticks(2);
    end
    do_complete(5);
    do_complete(7);
    do_complete(2);
    ie = '0;
    // threshold
    cfg(1, 3, 1);
    thresh = 3;
    src[0] = 1;
    tick();
    src[0] = 0;
    ticks(3);
    chk("thresh_eq", int'(irq), 0);
    thresh = 2;
    tick();
    chk("thresh_below", int'(irq), 1);
    do_claim();
    chk("thresh_claim", int'(claim_id), 1);
    thresh = 0;
    ticks(2);
    // gating: ID4 held high while in service, ID1 still in service
    cfg(4, 2, 1);
    src[3] = 1;
    ticks(3);
    do_claim();
    chk("gate_claim", int'(claim_id), 4);
    ticks(3);
    chk("gate_nopend", int'(pending[3]), 0);
    do_complete(9);
    ticks(2);
    chk("gate_bad_id", int'(pending[3]), 0);
    do_complete(4);
    chk("gate_cmp_idle", int'(pending[3]), 0);
    tick();
    chk("gate_repend", int'(pending[3]), 1);
    ticks(2);
    // claim of 4 and complete of 1 in the same cycle
    claim = 1;
    complete = 1;
    complete_id = 1;
    tick();
    {claim, complete} = '0;
    chk("simul_claim", int'(claim_id), 4);
    src[3] = 0;
    ticks(2);
    do_complete(4);
    // disabled or zero-priority pending source
    cfg(8, 5, 0);
    src[7] = 1;
    tick();
    src[7] = 0;
    ticks(3);
    chk("ie0_irq", int'(irq), 0);
    chk("ie0_pend", int'(pending[7]), 1);
    cfg(8, 0, 1);
    ticks(3);
    chk("prio0_irq", int'(irq), 0);
    chk("prio0_pend", int'(pending[7]), 1);
    // reset mid-service
    cfg(6, 7, 1);
    src[5] = 1;
    ticks(3);
    do_claim();
    chk("rstsvc_claim", int'(claim_id), 6);
    ticks(2);
    rst = 1;
    tick();
    rst = 0;
    chk("rstsvc_irq", int'(irq), 0);
    chk("rstsvc_id", int'(claim_id), 0);
    chk("rstsvc_pend", int'(pending), 0);
    tick();
    chk("rstsvc_repend", int'(pending[5]), 1);
    src = '0;
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      src = NSRC'($urandom) & NSRC'($urandom);
      if ($urandom_range(0, 15) == 0) ie = NSRC'($urandom);
      if ($urandom_range(0, 15) == 0) prio = {$urandom, $urandom};
      if ($urandom_range(0, 31) == 0) thresh = 3'($urandom);
      claim = $urandom_range(0, 3) == 0;
      complete = $urandom_range(0, 2) == 0;
      complete_id = 4'($urandom);
      rst = $urandom_range(0, 499) == 0;
      tick();
    end
    {rst, claim, complete} = '0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
